// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS-subset controller
// Contents: FSM state encoding, opcode/funct constants, ALU control codes,
// and the instruction-class enum produced by mc_decode.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ADDU,
    CL_SUBU,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction-class map
// Ports:
//   opcode  in   IR[31:26]
//   funct   in   IR[5:0], only meaningful for R-type
//   cls     out  decoded instruction class (CL_ILLEGAL for unsupported encodings)
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CL_ADDU;
          FN_SUBU: cls = CL_SUBU;
          FN_NOP:  cls = CL_NOP;
          default: cls = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LUI:  cls = CL_LUI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      default: cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   run                   permit a new fetch (sampled in FETCH only)
//   opcode, funct, zero   instruction fields from IR and the ALU zero flag
//   dm_ready              data-memory access complete
//   pc_we, ir_we, reg_we, dm_req, mem_we          datapath enables
//   npc_sel, reg_dst, alu_src, ext_op, alu_ctr, mem_to_reg   datapath selects
//   state                 current FSM state for debug
//   retire, illegal, bus_err   single-cycle event pulses
//   instr_cnt             retired-instruction count, wraps
module mc_controller
  import mips_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             npc_sel,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       alu_ctr,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             dm_req,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (DM_TIMEOUT > 2) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((DM_TIMEOUT > 0) ? DM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (DM_TIMEOUT > 0);

  state_e             state_q, state_d;
  instr_class_e       cls_q, dec_cls;
  logic [WAIT_W-1:0]  wait_q;

  logic pc_we_c, ir_we_c, reg_we_c, dm_req_c, mem_we_c;
  logic retire_c, illegal_c, bus_err_c;
  logic cls_alu_src, cls_ext_op;
  logic [2:0] cls_alu_ctr;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls)
  );

  // ALU/extender setup implied by the latched class; asserted in EXEC and
  // held through MEM and WB so the datapath result stays stable.
  always_comb begin
    cls_alu_ctr = ALU_ADD;
    cls_alu_src = 1'b0;
    cls_ext_op  = 1'b0;
    case (cls_q)
      CL_SUBU: cls_alu_ctr = ALU_SUB;
      CL_ORI: begin
        cls_alu_ctr = ALU_OR;
        cls_alu_src = 1'b1;
      end
      CL_LUI: begin
        cls_alu_ctr = ALU_LUI;
        cls_alu_src = 1'b1;
      end
      CL_LW, CL_SW: begin
        cls_alu_src = 1'b1;
        cls_ext_op  = 1'b1;
      end
      CL_BEQ: begin
        cls_alu_ctr = ALU_SUB;
        cls_ext_op  = 1'b1;
      end
      default: cls_alu_ctr = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    dm_req_c   = 1'b0;
    mem_we_c   = 1'b0;
    retire_c   = 1'b0;
    illegal_c  = 1'b0;
    bus_err_c  = 1'b0;
    npc_sel    = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_ctr    = ALU_ADD;
    mem_to_reg = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          pc_we_c = 1'b1;
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      // The class register is not loaded yet here, so DECODE looks at the
      // live decode of IR, which is already registered and stable.
      ST_DECODE: begin
        case (dec_cls)
          CL_ILLEGAL: begin
            illegal_c = 1'b1;
            state_d   = ST_FETCH;
          end
          CL_NOP: begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_ctr = cls_alu_ctr;
        alu_src = cls_alu_src;
        ext_op  = cls_ext_op;
        case (cls_q)
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_BEQ: begin
            npc_sel  = 1'b1;
            pc_we_c  = zero;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_ctr  = cls_alu_ctr;
        alu_src  = cls_alu_src;
        ext_op   = cls_ext_op;
        dm_req_c = 1'b1;
        mem_we_c = (cls_q == CL_SW);
        if (dm_ready) begin
          if (cls_q == CL_LW) begin
            state_d = ST_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          bus_err_c = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_WB: begin
        alu_ctr    = cls_alu_ctr;
        alu_src    = cls_alu_src;
        ext_op     = cls_ext_op;
        reg_we_c   = 1'b1;
        retire_c   = 1'b1;
        reg_dst    = (cls_q == CL_ADDU) || (cls_q == CL_SUBU);
        mem_to_reg = (cls_q == CL_LW);
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset is asynchronous, so FETCH with run=1 would otherwise raise pc_we
  // and ir_we while reset is still held; every enable and pulse is gated.
  assign pc_we   = reset & pc_we_c;
  assign ir_we   = reset & ir_we_c;
  assign reg_we  = reset & reg_we_c;
  assign dm_req  = reset & dm_req_c;
  assign mem_we  = reset & mem_we_c;
  assign retire  = reset & retire_c;
  assign illegal = reset & illegal_c;
  assign bus_err = reset & bus_err_c;
  assign state   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CL_NOP;
      wait_q    <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_DECODE) && (state_d == ST_EXEC)) begin
        cls_q <= dec_cls;
      end
      // Counts stall cycles only while staying in MEM; any exit clears it.
      if ((state_q == ST_MEM) && (state_d == ST_MEM)) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  localparam int TMO = 4;

  logic        clk, reset, run, zero, dm_ready;
  logic [5:0]  opcode, funct;
  logic        pc_we, ir_we, npc_sel, reg_dst, alu_src, ext_op, mem_to_reg;
  logic        reg_we, dm_req, mem_we, retire, illegal, bus_err;
  logic [2:0]  alu_ctr, state;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  int n_cyc, n_pc, n_ir, n_npc_pc, n_reg, n_mwe, n_req, n_ret, n_ill, n_berr;
  logic       wb_dst, wb_m2r;
  logic [2:0] wb_alu;
  logic [2:0] states[$];

  mc_controller #(.CNT_W(32), .DM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .dm_ready(dm_ready), .pc_we(pc_we), .ir_we(ir_we),
    .npc_sel(npc_sel), .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op),
    .alu_ctr(alu_ctr), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
    .dm_req(dm_req), .mem_we(mem_we), .state(state), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from FETCH back to FETCH and tallies what was seen.
  // w is the number of MEM cycles before dm_ready is raised.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int w);
    int  mem_seen;
    bit  done;
    mem_seen = 0;
    done = 0;
    n_pc = 0; n_ir = 0; n_npc_pc = 0; n_reg = 0; n_mwe = 0;
    n_req = 0; n_ret = 0; n_ill = 0; n_berr = 0;
    wb_dst = 1'b0; wb_m2r = 1'b0; wb_alu = 3'b000;
    states.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      run    = (c == 0);
      opcode = op;
      funct  = fn;
      zero   = z;
      dm_ready = dm_req ? (mem_seen == w) : 1'($urandom_range(0, 1));
      #1;
      states.push_back(state);
      if (pc_we)   n_pc++;
      if (ir_we)   n_ir++;
      if (pc_we && npc_sel) n_npc_pc++;
      if (mem_we)  n_mwe++;
      if (retire)  n_ret++;
      if (illegal) n_ill++;
      if (bus_err) n_berr++;
      if (dm_req) begin
        n_req++;
        mem_seen++;
      end
      if (reg_we) begin
        n_reg++;
        wb_dst = reg_dst;
        wb_m2r = mem_to_reg;
        wb_alu = alu_ctr;
      end
      @(posedge clk);
      #1;
      if (state == 3'd0) begin
        done = 1;
        break;
      end
    end
    n_cyc = states.size();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL instr_timeout op=%h fn=%h: still in state %0d, required return to 0", op, fn, state);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b1; opcode = 6'h00; funct = 6'h21; zero = 1'b0; dm_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({state, pc_we, ir_we, reg_we, dm_req, mem_we, retire} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d pc_we=%b ir_we=%b reg_we=%b dm_req=%b mem_we=%b retire=%b, required all 0",
               state, pc_we, ir_we, reg_we, dm_req, mem_we, retire);
    end
    n_checks++;
    if ({npc_sel, reg_dst, alu_src, ext_op, alu_ctr, mem_to_reg, illegal, bus_err} !== 10'b0 || instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_selects: selects=%b cnt=%0d, required 0", {npc_sel, reg_dst, alu_src, ext_op, alu_ctr, mem_to_reg}, instr_cnt);
    end
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_addu;
    logic [2:0] exp_st[4];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    run_instr(6'h00, 6'h21, 1'b0, 0);
    exp_cnt++;
    n_checks++;
    if (n_cyc != 4 || states[0] !== exp_st[0] || states[1] !== exp_st[1] ||
        states[2] !== exp_st[2] || states[3] !== exp_st[3]) begin
      n_fail++;
      $display("FAIL addu_states: got %0d cycles %p, required 0,1,2,4", n_cyc, states);
    end
    n_checks++;
    if (n_pc != 1 || n_ir != 1 || n_reg != 1 || wb_dst !== 1'b1 || wb_m2r !== 1'b0 || wb_alu !== 3'b000) begin
      n_fail++;
      $display("FAIL addu_ctrl: pc=%0d ir=%0d reg=%0d dst=%b m2r=%b alu=%b, required 1,1,1,1,0,000",
               n_pc, n_ir, n_reg, wb_dst, wb_m2r, wb_alu);
    end
    n_checks++;
    if (n_ret != 1 || instr_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL addu_retire: retire=%0d cnt=%0d, required 1 and %0d", n_ret, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_lw;
    run_instr(6'h23, 6'h00, 1'b0, 3);
    exp_cnt++;
    n_checks++;
    if (n_cyc != 8 || n_req != 4 || n_mwe != 0) begin
      n_fail++;
      $display("FAIL lw_stall: cycles=%0d dm_req=%0d mem_we=%0d, required 8,4,0", n_cyc, n_req, n_mwe);
    end
    n_checks++;
    if (n_reg != 1 || wb_m2r !== 1'b1 || wb_dst !== 1'b0 || n_ret != 1 || instr_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL lw_wb: reg=%0d m2r=%b dst=%b ret=%0d cnt=%0d, required 1,1,0,1,%0d",
               n_reg, wb_m2r, wb_dst, n_ret, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      run_instr(6'h04, 6'h00, 1'(z), 0);
      exp_cnt++;
      n_checks++;
      if (n_cyc != 3 || n_pc != 1 + z || n_npc_pc != z || n_ret != 1 || n_reg != 0 || instr_cnt !== 32'(exp_cnt)) begin
        n_fail++;
        $display("FAIL beq_z%0d: cycles=%0d pc=%0d npc_pc=%0d ret=%0d reg=%0d cnt=%0d, required 3,%0d,%0d,1,0,%0d",
                 z, n_cyc, n_pc, n_npc_pc, n_ret, n_reg, instr_cnt, 1 + z, z, exp_cnt);
      end
    end
  endtask

  task automatic test_sw_timeout;
    run_instr(6'h2B, 6'h00, 1'b0, 100);
    n_checks++;
    if (n_cyc != 3 + TMO || n_req != TMO || n_mwe != TMO || n_berr != 1) begin
      n_fail++;
      $display("FAIL sw_timeout: cycles=%0d dm_req=%0d mem_we=%0d bus_err=%0d, required %0d,%0d,%0d,1",
               n_cyc, n_req, n_mwe, n_berr, 3 + TMO, TMO, TMO);
    end
    n_checks++;
    if (n_ret != 0 || n_reg != 0 || instr_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL sw_timeout_noretire: ret=%0d reg=%0d cnt=%0d, required 0,0,%0d", n_ret, n_reg, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal_idle;
    run_instr(6'h3F, 6'h00, 1'b0, 0);
    n_checks++;
    if (n_cyc != 2 || n_ill != 1 || n_reg != 0 || n_mwe != 0 || n_ret != 0 || instr_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL illegal: cycles=%0d ill=%0d reg=%0d mwe=%0d ret=%0d cnt=%0d, required 2,1,0,0,0,%0d",
               n_cyc, n_ill, n_reg, n_mwe, n_ret, instr_cnt, exp_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      run = 1'b0;
      dm_ready = 1'b1;
      #1;
      n_checks++;
      if (state !== 3'd0 || pc_we !== 1'b0 || ir_we !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold c%0d: state=%0d pc_we=%b ir_we=%b, required 0,0,0", c, state, pc_we, ir_we);
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      run = (c == 0);
      opcode = 6'h2B;
      funct = 6'h00;
      dm_ready = 1'b0;
      #1;
    end
    n_checks++;
    if (state !== 3'd3 || dm_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mem_pre: state=%0d dm_req=%b mem_we=%b, required 3,1,1", state, dm_req, mem_we);
    end
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (state !== 3'd0 || dm_req !== 1'b0 || mem_we !== 1'b0 || instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mem: state=%0d dm_req=%b mem_we=%b cnt=%0d, required 0,0,0,0", state, dm_req, mem_we, instr_cnt);
    end
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dm_ready = 1'b1;
      #1;
      n_checks++;
      if (state !== 3'd0 || mem_we !== 1'b0 || reg_we !== 1'b0 || instr_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL rst_mem_after c%0d: state=%0d mem_we=%b reg_we=%b cnt=%0d, required 0,0,0,0",
                 c, state, mem_we, reg_we, instr_cnt);
      end
    end
  endtask

  // Reference model: expected per-instruction tallies from the class rules.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w,
                       output int lat, output int ret, output int rw, output int mwe,
                       output int req, output int ill, output int berr, output int pc,
                       output logic dst, output logic m2r, output logic [2:0] alu);
    bit to;
    to = (w >= TMO);
    lat = 2; ret = 0; rw = 0; mwe = 0; req = 0; ill = 0; berr = 0; pc = 1;
    dst = 1'b0; m2r = 1'b0; alu = 3'b000;
    if (op == 6'h00 && fn == 6'h00) begin
      ret = 1;
    end else if ((op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) || op == 6'h0D || op == 6'h0F) begin
      lat = 4; ret = 1; rw = 1;
      dst = (op == 6'h00);
      alu = (op == 6'h0D) ? 3'd2 : (op == 6'h0F) ? 3'd3 : (fn == 6'h23) ? 3'd1 : 3'd0;
    end else if (op == 6'h23 || op == 6'h2B) begin
      if (to) begin
        lat = 3 + TMO; req = TMO; berr = 1;
        mwe = (op == 6'h2B) ? TMO : 0;
      end else begin
        req = w + 1;
        ret = 1;
        if (op == 6'h23) begin
          lat = 5 + w; rw = 1; m2r = 1'b1;
        end else begin
          lat = 4 + w; mwe = w + 1;
        end
      end
    end else if (op == 6'h04) begin
      lat = 3; ret = 1; pc = 1 + int'(z);
    end else begin
      ill = 1;
    end
  endtask

  task automatic test_random;
    logic [5:0] ops[7];
    logic [5:0] fns[4];
    logic [5:0] op, fn;
    logic       z, e_dst, e_m2r;
    logic [2:0] e_alu;
    int w, e_lat, e_ret, e_rw, e_mwe, e_req, e_ill, e_berr, e_pc;
    ops = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h00};
    fns = '{6'h21, 6'h23, 6'h00, 6'h00};
    for (int i = 0; i < 40; i++) begin
      ops[6] = 6'($urandom);
      fns[3] = 6'($urandom);
      op = ops[$urandom_range(0, 6)];
      fn = fns[$urandom_range(0, 3)];
      z  = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 5);
      model(op, fn, z, w, e_lat, e_ret, e_rw, e_mwe, e_req, e_ill, e_berr, e_pc, e_dst, e_m2r, e_alu);
      run_instr(op, fn, z, w);
      exp_cnt += e_ret;
      n_checks++;
      if (n_cyc != e_lat || n_ret != e_ret || n_ill != e_ill || n_berr != e_berr) begin
        n_fail++;
        $display("FAIL rand%0d_flow op=%h fn=%h w=%0d: lat=%0d ret=%0d ill=%0d berr=%0d, required %0d,%0d,%0d,%0d",
                 i, op, fn, w, n_cyc, n_ret, n_ill, n_berr, e_lat, e_ret, e_ill, e_berr);
      end
      n_checks++;
      if (n_reg != e_rw || n_mwe != e_mwe || n_req != e_req || n_pc != e_pc || n_ir != 1) begin
        n_fail++;
        $display("FAIL rand%0d_en op=%h fn=%h: reg=%0d mwe=%0d req=%0d pc=%0d ir=%0d, required %0d,%0d,%0d,%0d,1",
                 i, op, fn, n_reg, n_mwe, n_req, n_pc, n_ir, e_rw, e_mwe, e_req, e_pc);
      end
      if (e_rw != 0) begin
        n_checks++;
        if (wb_dst !== e_dst || wb_m2r !== e_m2r || wb_alu !== e_alu) begin
          n_fail++;
          $display("FAIL rand%0d_wb op=%h fn=%h: dst=%b m2r=%b alu=%b, required %b,%b,%b",
                   i, op, fn, wb_dst, wb_m2r, wb_alu, e_dst, e_m2r, e_alu);
        end
      end
      n_checks++;
      if (instr_cnt !== 32'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand%0d_cnt: cnt=%0d, required %0d", i, instr_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset;
    test_addu;
    test_lw;
    test_beq;
    test_sw_timeout;
    test_illegal_idle;
    test_reset_mid_mem;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
